// File: rtl/cordic_issue_sched.sv
// Round-robin issue scheduler sharing one pipelined CORDIC datapath between NREQ requesters.
// Tracks slot valid/tag through LAT stages; an unaccepted result freezes the whole pipeline via pipe_ce.
module cordic_issue_sched #(
  parameter int W    = 18,
  parameter int NREQ = 4,
  parameter int LAT  = 14,
  parameter int TW   = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*W-1:0]          req_angle,
  output logic [NREQ-1:0]            req_ready,
  output logic                       pipe_ce,
  output logic [W-1:0]               pipe_angle,
  input  logic [W-1:0]               pipe_sin,
  input  logic [W-1:0]               pipe_cos,
  output logic                       res_valid,
  output logic [TW-1:0]              res_tag,
  output logic [W-1:0]               res_sin,
  output logic [W-1:0]               res_cos,
  input  logic                       res_ready,
  output logic [$clog2(LAT+1)-1:0]   in_flight
);

  localparam int CW = $clog2(LAT+1);

  logic [LAT-1:0] vld;
  logic [TW-1:0]  tag [LAT];
  logic [TW-1:0]  ptr;
  logic [TW-1:0]  win;
  logic [TW:0]    idx;
  logic           found;
  logic           issue;
  logic           res_xfer;

  // Gating with resetn keeps stale slots invisible in the reset cycle itself.
  assign res_valid = resetn & vld[LAT-1];
  assign res_tag   = tag[LAT-1];
  assign res_sin   = pipe_sin;
  assign res_cos   = pipe_cos;
  assign pipe_ce   = resetn & (~res_valid | res_ready);
  assign issue     = pipe_ce & found;
  assign res_xfer  = res_valid & res_ready;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (TW+1)'(k);
      if (idx >= (TW+1)'(NREQ))
        idx = idx - (TW+1)'(NREQ);
      if (!found && req_valid[idx[TW-1:0]]) begin
        found = 1'b1;
        win   = idx[TW-1:0];
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    pipe_angle = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (win == TW'(i))) begin
        req_ready[i] = 1'b1;
        pipe_angle   = req_angle[i*W +: W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld       <= '0;
      ptr       <= '0;
      in_flight <= '0;
    end else begin
      if (pipe_ce) begin
        vld <= {vld[LAT-2:0], issue};
        if (issue)
          ptr <= (win == TW'(NREQ-1)) ? '0 : win + TW'(1);
      end
      if (issue && !res_xfer)
        in_flight <= in_flight + CW'(1);
      else if (!issue && res_xfer)
        in_flight <= in_flight - CW'(1);
    end
  end

  // Tags are qualified by vld, so they need no reset.
  always_ff @(posedge clock) begin
    if (pipe_ce) begin
      tag[0] <= win;
      for (int k = 1; k < LAT; k++)
        tag[k] <= tag[k-1];
    end
  end

endmodule

// File: tb/tb_cordic_issue_sched.sv
// Directed bench for cordic_issue_sched with a stand-in pipeline (sin = angle+1, cos = ~angle).
module tb_cordic_issue_sched;
  localparam int W    = 18;
  localparam int NREQ = 4;
  localparam int LAT  = 14;
  localparam int TW   = 2;
  localparam int CW   = $clog2(LAT+1);

  logic                 clock = 1'b0;
  logic                 resetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_angle;
  logic [NREQ-1:0]      req_ready;
  logic                 pipe_ce;
  logic [W-1:0]         pipe_angle;
  logic [W-1:0]         pipe_sin;
  logic [W-1:0]         pipe_cos;
  logic                 res_valid;
  logic [TW-1:0]        res_tag;
  logic [W-1:0]         res_sin;
  logic [W-1:0]         res_cos;
  logic                 res_ready;
  logic [CW-1:0]        in_flight;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pa [LAT];

  cordic_issue_sched #(.W(W), .NREQ(NREQ), .LAT(LAT), .TW(TW)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .pipe_ce(pipe_ce), .pipe_angle(pipe_angle),
    .pipe_sin(pipe_sin), .pipe_cos(pipe_cos),
    .res_valid(res_valid), .res_tag(res_tag), .res_sin(res_sin), .res_cos(res_cos),
    .res_ready(res_ready), .in_flight(in_flight)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pipe_ce) begin
      pa[0] <= pipe_angle;
      for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
    end
  end
  assign pipe_sin = pa[LAT-1] + 18'd1;
  assign pipe_cos = pa[LAT-1] ^ 18'h3FFFF;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    tick();
    resetn    = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < LAT; k++) pa[k] = '0;
    resetn    = 1'b0;
    req_valid = 4'hF;
    req_angle = {18'h3, 18'h2, 18'h1, 18'h4};
    res_ready = 1'b1;

    // reset state with requests pending
    tick(); tick(); settle();
    chk("rst_ce", pipe_ce, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_angle", pipe_angle, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_flight", in_flight, 0);
    do_reset();

    // single request from requester 2
    req_valid = 4'b0100;
    req_angle = '0;
    req_angle[2*W +: W] = 18'h0C90;
    settle();
    chk("single_ready", req_ready, 4'b0100);
    chk("single_angle", pipe_angle, 18'h0C90);
    tick();
    req_valid = '0;
    settle();
    chk("single_inflight1", in_flight, 1);
    for (int c = 1; c < LAT; c++) begin
      chk("single_early", res_valid, 0);
      tick(); settle();
    end
    chk("single_valid", res_valid, 1);
    chk("single_tag", res_tag, 2);
    chk("single_sin", res_sin, 18'h0C91);
    chk("single_cos", res_cos, 18'h3F36F);
    tick(); settle();
    chk("single_inflight0", in_flight, 0);
    chk("single_gone", res_valid, 0);

    // all four requesters, back-to-back
    do_reset();
    req_valid = 4'hF;
    req_angle = {18'h103, 18'h102, 18'h101, 18'h100};
    for (int c = 0; c < 22; c++) begin
      settle();
      chk("all_grant", req_ready, 4'b0001 << (c % 4));
      chk("all_angle", pipe_angle, 18'h100 + (c % 4));
      chk("all_inflight", in_flight, (c < LAT) ? c : LAT);
      if (c >= LAT) begin
        chk("all_res_valid", res_valid, 1);
        chk("all_res_tag", res_tag, (c - LAT) % 4);
        chk("all_res_sin", res_sin, 18'h101 + ((c - LAT) % 4));
      end else begin
        chk("all_res_early", res_valid, 0);
      end
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < LAT; c++) tick();
    settle();
    chk("all_drained", in_flight, 0);
    chk("all_drained_vld", res_valid, 0);

    // fairness: requesters 0 and 2 only
    do_reset();
    req_valid = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("fair_grant", req_ready, (c % 2 == 0) ? 4'b0001 : 4'b0100);
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 20; c++) tick();
    settle();
    chk("fair_drained", in_flight, 0);

    // backpressure
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0010;
    req_angle = '0;
    req_angle[1*W +: W] = 18'h2A;
    settle();
    chk("bp_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int c = 1; c < LAT; c++) tick();
    settle();
    chk("bp_arrive", res_valid, 1);
    chk("bp_arrive_tag", res_tag, 1);
    req_valid = 4'b1000;
    req_angle[3*W +: W] = 18'h33;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_ce", pipe_ce, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", res_valid, 1);
      chk("bp_tag", res_tag, 1);
      chk("bp_sin", res_sin, 18'h2B);
      chk("bp_cos", res_cos, 18'h3FFD5);
      chk("bp_inflight", in_flight, 1);
      tick();
    end
    res_ready = 1'b1;
    settle();
    chk("bp_release_ce", pipe_ce, 1);
    chk("bp_release_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    settle();
    chk("bp_after_inflight", in_flight, 1);
    chk("bp_after_valid", res_valid, 0);
    for (int c = 0; c < 16; c++) tick();
    settle();
    chk("bp_drained", in_flight, 0);

    // reset mid-flight
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c < 6; c++) tick();
    req_valid = '0;
    tick(); tick();
    settle();
    chk("mid_inflight6", in_flight, 6);
    resetn    = 1'b0;
    req_valid = 4'b0110;
    settle();
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_ce", pipe_ce, 0);
    tick();
    resetn = 1'b1;
    settle();
    chk("mid_inflight0", in_flight, 0);
    chk("mid_first_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int c = 10; c < 23; c++) begin
      settle();
      chk("mid_no_stale", res_valid, 0);
      tick();
    end
    settle();
    chk("mid_new_valid", res_valid, 1);
    chk("mid_new_tag", res_tag, 1);
    for (int c = 0; c < 3; c++) tick();

    // bubbles: issue at cycles 0 and 3 only
    do_reset();
    req_angle = '0;
    req_angle[0*W +: W] = 18'h11;
    req_angle[3*W +: W] = 18'h44;
    for (int c = 0; c < 21; c++) begin
      req_valid = (c == 0) ? 4'b0001 : (c == 3) ? 4'b1000 : 4'b0000;
      settle();
      chk("bub_angle", pipe_angle, (c == 0) ? 18'h11 : (c == 3) ? 18'h44 : 18'h0);
      chk("bub_res_valid", res_valid, (c == 14 || c == 17) ? 1 : 0);
      if (c == 17) chk("bub_tag", res_tag, 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
